// File: rtl/outarb_pkg.sv
//------------------------------------------------------------------------------
// outarb_pkg: flit type codes, channel widths and FSM states for outarb.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package outarb_pkg;

  localparam int TYPEW  = 1;
  localparam int VCHW   = 0;
  localparam int VCH    = 1;
  localparam int PKTLEN = 8;

  localparam logic [TYPEW:0] TYPE_BODY     = 2'b00;
  localparam logic [TYPEW:0] TYPE_HEAD     = 2'b01;
  localparam logic [TYPEW:0] TYPE_TAIL     = 2'b10;
  localparam logic [TYPEW:0] TYPE_HEADTAIL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_head(input logic [TYPEW:0] t);
    return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
  endfunction

  function automatic logic is_tail(input logic [TYPEW:0] t);
    return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/outarb_rrarb.sv
//------------------------------------------------------------------------------
// rrarb: combinational round-robin picker, first request at or after ptr.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rrarb #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [PW-1:0] w_j;
      w_j = PW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[w_j]) begin
        any_o        = 1'b1;
        win_o[w_j]   = 1'b1;
        idx_o        = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/outarb.sv
//------------------------------------------------------------------------------
// outarb: packet-granular round-robin switch arbiter for one output channel.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module outarb
  import outarb_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int NPORT    = 5
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [NPORT-1:0]          ireq,
  input  logic [NPORT*(VCHW+1)-1:0] ivch,
  input  logic [NPORT*(TYPEW+1)-1:0] itype,
  input  logic [VCH:0]              ordy,
  input  logic [VCH:0]              olck,
  output logic [NPORT-1:0]          ogrant,
  output logic [2:0]                osel,
  output logic [VCHW:0]             ovch,
  output logic                      obusy,
  output logic                      oxfer,
  output logic                      oerr
);

  localparam int c_ptrw = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int c_fcw  = $clog2(PKTLEN + 1);

  // osel is 3 bits wide, so more than 8 ports cannot be encoded
  if (NPORT < 1 || NPORT > 8 || ROUTERID < 0 || PCHID < 0) begin : g_cfg_bad
    $error("outarb: unsupported configuration");
  end

  state_e             state_q, state_d;
  logic [c_ptrw-1:0]  ptr_q, ptr_d;
  logic [c_ptrw-1:0]  sel_q, sel_d;
  logic [c_fcw-1:0]   fcnt_q, fcnt_d;
  logic [NPORT-1:0]   grant_q, grant_d;
  logic [VCHW:0]      vch_q, vch_d;
  logic               err_q, err_d;

  logic [TYPEW:0]     w_type [NPORT];
  logic [VCHW:0]      w_vch  [NPORT];
  logic [NPORT-1:0]   w_elig;
  logic [NPORT-1:0]   w_win;
  logic [c_ptrw-1:0]  w_win_idx;
  logic               w_any;
  logic               w_xfer;
  logic               w_cur_tail;
  logic               w_last;
  logic [c_ptrw-1:0]  w_ptr_next;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign w_type[gi] = itype[gi*(TYPEW+1) +: TYPEW+1];
    assign w_vch[gi]  = ivch[gi*(VCHW+1) +: VCHW+1];
    assign w_elig[gi] = ireq[gi] & is_head(w_type[gi])
                      & ordy[w_vch[gi]] & ~olck[w_vch[gi]];
  end

  rrarb #(
    .N  (NPORT),
    .PW (c_ptrw)
  ) u_rrarb (
    .req_i (w_elig),
    .ptr_i (ptr_q),
    .win_o (w_win),
    .idx_o (w_win_idx),
    .any_o (w_any)
  );

  assign w_xfer     = (state_q == ST_BUSY) & ireq[sel_q];
  assign w_cur_tail = is_tail(w_type[sel_q]);
  // A packet that reaches PKTLEN flits without a tail is cut off here
  assign w_last     = w_cur_tail | (fcnt_q == c_fcw'(PKTLEN - 1));
  assign w_ptr_next = (sel_q == c_ptrw'(NPORT - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    fcnt_d  = fcnt_q;
    grant_d = grant_q;
    vch_d   = vch_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          state_d = ST_BUSY;
          grant_d = w_win;
          sel_d   = w_win_idx;
          vch_d   = w_vch[w_win_idx];
          fcnt_d  = '0;
        end
      end
      ST_BUSY: begin
        if (w_xfer) begin
          fcnt_d = fcnt_q + 1'b1;
          if (w_last) begin
            state_d = ST_IDLE;
            ptr_d   = w_ptr_next;
            grant_d = '0;
            sel_d   = '0;
            vch_d   = '0;
            if (!w_cur_tail) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      fcnt_q  <= '0;
      grant_q <= '0;
      vch_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      fcnt_q  <= fcnt_d;
      grant_q <= grant_d;
      vch_q   <= vch_d;
      err_q   <= err_d;
    end
  end

  assign ogrant = grant_q;
  assign osel   = 3'(sel_q);
  assign ovch   = vch_q;
  assign obusy  = (state_q == ST_BUSY);
  assign oxfer  = w_xfer;
  assign oerr   = err_q;

endmodule

`default_nettype wire
